// File: rtl/ext_block_sequencer.sv
// ext_block_sequencer: executes one extension-block instruction by streaming
// `count` blocks from memory through the selected extension module and
// writing the results back, stalling the core for the duration.
module ext_block_sequencer #(
  parameter int NUM_MODULES   = 2,
  parameter int BLOCK_BITS    = 128,
  parameter int MEM_WORD_BITS = 32,
  parameter int COUNT_BITS    = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid,
  input  logic [2:0]                 funct3,
  input  logic [31:0]                src_base,
  input  logic [31:0]                dst_base,
  input  logic [COUNT_BITS-1:0]      count,
  output logic                       issue_ready,
  output logic                       stall,
  output logic                       busy,
  output logic                       done_pulse,
  output logic                       err,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [MEM_WORD_BITS-1:0]   mem_wdata,
  output logic [MEM_WORD_BITS/8-1:0] mem_byteena,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [MEM_WORD_BITS-1:0]   mem_rdata,
  output logic                       ext_start,
  output logic [2:0]                 ext_sel,
  output logic [BLOCK_BITS-1:0]      ext_din,
  input  logic                       ext_done,
  input  logic [BLOCK_BITS-1:0]      ext_dout
);

  localparam int WORDS  = BLOCK_BITS / MEM_WORD_BITS;
  localparam int WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [31:0]       BLOCK_BYTES = 32'(BLOCK_BITS / 8);
  localparam logic [31:0]       WORD_BYTES  = 32'(MEM_WORD_BITS / 8);
  localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_STORE, S_NEXT, S_DONE
  } state_t;

  state_t                              state_q, state_d;
  logic [2:0]                          sel_q;
  logic [31:0]                         src_q, dst_q, blk_off_q;
  logic [COUNT_BITS-1:0]               rem_q;
  logic                                bad_sel_q;
  logic [WIDX_W-1:0]                   word_q;
  logic                                rd_wait_q;  // read granted, data not yet back
  logic                                started_q;  // ext_start already issued this RUN
  logic [WORDS-1:0][MEM_WORD_BITS-1:0] din_q, dout_q;

  logic        accept, bad_sel, last_word;
  logic [31:0] base, addr_raw;

  assign accept    = (state_q == S_IDLE) && issue_valid;
  assign bad_sel   = (funct3 == 3'd0) || (funct3 > 3'(NUM_MODULES));
  assign last_word = (word_q == LAST_WORD);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode.
  // NOTE: the default assignment first guarantees state_d is driven on every
  // path, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue_valid) begin
                 if (bad_sel || (count == '0)) state_d = S_DONE;
                 else                          state_d = S_LOAD;
               end
      S_LOAD:  if (rd_wait_q && mem_rvalid && last_word) state_d = S_RUN;
      S_RUN:   if (started_q && ext_done) state_d = S_STORE;
      S_STORE: if (mem_gnt && last_word) state_d = S_NEXT;
      S_NEXT:  state_d = (rem_q > COUNT_BITS'(1)) ? S_LOAD : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction latch, block/word counters and block data buffers.
  // NOTE: the block buffers are reset as well because din_q drives ext_din
  // directly and every output must read zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      blk_off_q <= '0;
      rem_q     <= '0;
      bad_sel_q <= 1'b0;
      word_q    <= '0;
      rd_wait_q <= 1'b0;
      started_q <= 1'b0;
      din_q     <= '0;
      dout_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (issue_valid) begin
          sel_q     <= funct3;
          src_q     <= src_base;
          dst_q     <= dst_base;
          rem_q     <= count;
          bad_sel_q <= bad_sel;
          blk_off_q <= '0;
          word_q    <= '0;
          rd_wait_q <= 1'b0;
          started_q <= 1'b0;
        end
        S_LOAD: begin
          if (!rd_wait_q) begin
            if (mem_gnt) rd_wait_q <= 1'b1;
          end else if (mem_rvalid) begin
            din_q[word_q] <= mem_rdata;
            rd_wait_q     <= 1'b0;
            word_q        <= last_word ? '0 : word_q + 1'b1;
          end
        end
        S_RUN: begin
          // ext_done in the ext_start cycle is ignored: only sampled once started.
          if (!started_q) begin
            started_q <= 1'b1;
          end else if (ext_done) begin
            dout_q    <= ext_dout;
            started_q <= 1'b0;
          end
        end
        S_STORE: if (mem_gnt) word_q <= last_word ? '0 : word_q + 1'b1;
        S_NEXT: begin
          blk_off_q <= blk_off_q + BLOCK_BYTES;
          rem_q     <= rem_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Address generation: base + block offset + word offset, modulo 2^32.
  assign base     = (state_q == S_STORE) ? dst_q : src_q;
  assign addr_raw = base + blk_off_q + 32'(word_q) * WORD_BYTES;

  // Memory request decode; a request stays put until granted because all of
  // its inputs only change on mem_gnt.
  assign mem_req     = ((state_q == S_LOAD) && !rd_wait_q) || (state_q == S_STORE);
  assign mem_we      = (state_q == S_STORE);
  assign mem_addr    = mem_req ? addr_raw : '0;
  assign mem_wdata   = mem_we ? dout_q[word_q] : '0;
  assign mem_byteena = {(MEM_WORD_BITS/8){mem_req}};

  // Extension command and status decode.
  assign ext_start   = (state_q == S_RUN) && !started_q;
  assign ext_din     = din_q;
  assign issue_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ext_sel     = busy ? sel_q : 3'd0;
  assign done_pulse  = (state_q == S_DONE);
  assign err         = done_pulse && bad_sel_q;
  assign stall       = accept || (state_q == S_LOAD) || (state_q == S_RUN) ||
                       (state_q == S_STORE) || (state_q == S_NEXT);

endmodule

// File: doc/ext_block_sequencer.md
# ext_block_sequencer

Multi-cycle sequencer for the extension unit. It accepts one decoded extension-block instruction (I-type, `funct3` selects the module, `rs1` value is the source base, `rd` value is the destination base, `imm[11:0]` is the block count). It then streams `count` blocks of `BLOCK_BITS` each: it reads each block from memory, hands it to the selected extension module, and writes the result back. While it runs, it stalls the core.

## Interface
- `NUM_MODULES`, default 2: valid selects are 1..NUM_MODULES (1 = aes-128 encrypt, 2 = aes-128 decrypt); maximum 7.
- `BLOCK_BITS`, default 128: bits per extension block.
- `MEM_WORD_BITS`, default 32: memory data width. `BLOCK_BITS` must be an integer multiple of it. WORDS = BLOCK_BITS/MEM_WORD_BITS.
- `COUNT_BITS`, default 12: width of the block count.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `issue_valid` in 1: extension-block instruction present in decode.
- `funct3` in 3: module select.
- `src_base` in 32: source byte address.
- `dst_base` in 32: destination byte address.
- `count` in COUNT_BITS: number of blocks.
- `issue_ready` out 1: high only in IDLE.
- `stall` out 1: the core holds PC (pcWE low) while this is high.
- `busy` out 1: state is not IDLE.
- `done_pulse` out 1: one cycle, instruction retired.
- `err` out 1: one cycle with done_pulse, for an invalid select.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out MEM_WORD_BITS, `mem_byteena` out MEM_WORD_BITS/8: memory request.
- `mem_gnt` in 1: request accepted.
- `mem_rvalid` in 1, `mem_rdata` in MEM_WORD_BITS: read return.
- `ext_start` out 1, `ext_sel` out 3, `ext_din` out BLOCK_BITS: extension module command.
- `ext_done` in 1, `ext_dout` in BLOCK_BITS: extension module result.

## Operation
- **Accept.** In IDLE, `issue_valid` = 1 accepts the instruction. On acceptance the block latches `funct3`, `src_base`, `dst_base` and `count`. `stall` goes high combinationally in the acceptance cycle.
- **Fast paths.** If `funct3` is 0 or greater than NUM_MODULES, the next state is DONE with `err` = 1. If `count` = 0, the next state is DONE. Neither path makes any memory access or asserts `ext_start`.
- **States:**
  - IDLE → LOAD on a valid accept.
  - LOAD: reads WORDS words, then → RUN.
  - RUN: `ext_start` is high for the first RUN cycle only. `ext_done` is sampled from the following cycle onward. When it is seen, capture `ext_dout` and → STORE.
  - STORE: writes WORDS words, then → NEXT.
  - NEXT: increment the block index and decrement the remaining count. If remaining > 0 → LOAD, else → DONE.
  - DONE: `done_pulse` = 1, `stall` = 0, `issue_ready` = 0; → IDLE.
  - DONE exists so that the instruction the core still holds in decode is not re-accepted.
- **Addressing.**
  - Read word w of block b: `src_base` + b·(BLOCK_BITS/8) + w·(MEM_WORD_BITS/8).
  - Writes use the same formula with `dst_base`.
  - All address arithmetic is 32-bit modulo 2^32 (wraps silently).
- **Data packing.** Word w maps to block bits [w·MEM_WORD_BITS +: MEM_WORD_BITS]. This applies both to reads into `ext_din` and to writes from the captured `ext_dout`.
- **Memory handshake.**
  - One outstanding access at a time.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` and `mem_byteena` are held stable until the cycle in which `mem_gnt` = 1.
  - A write completes on `mem_gnt`.
  - A read completes on `mem_rvalid`, which arrives at least 1 cycle after `mem_gnt`. The next read request is raised the cycle after `mem_rvalid`.
  - `mem_byteena` is all ones when `mem_req` = 1, and 0 otherwise.
- **Extension outputs.** `ext_sel` equals the latched `funct3` while busy, and 0 otherwise. `ext_din` is held stable throughout RUN.
- **Ignored inputs.** `ext_done` outside RUN, or in the same cycle as `ext_start`, is ignored. `mem_rvalid` outside an outstanding read is ignored.

## Timing
- **Reset values.** All outputs are 0, the state is IDLE and the counters are cleared. Exception: `issue_ready` = 1, because the block is in IDLE.
- **Reset mid-operation.** Asserting `rst` returns the block to IDLE immediately. Any in-flight memory access or extension command is abandoned, and no `done_pulse` is produced.
- **Output registration.** `stall` is combinational: IDLE & `issue_valid`, or state in {LOAD, RUN, STORE, NEXT}. All other outputs are registered or decoded from state only.
- **Per-block latency** with `mem_gnt` tied high, `mem_rvalid` 1 cycle after `mem_gnt`, and the extension module returning `ext_done` L cycles after `ext_start` (L ≥ 1):
  - LOAD: 2·WORDS cycles.
  - RUN: 1+L cycles.
  - STORE: WORDS cycles.
  - NEXT: 1 cycle.
  - DONE: 1 cycle at the end of the instruction.
- **Worked example.** Defaults, count = 1, L = 1, acceptance at T0: LOAD T1–T8, RUN T9–T10, STORE T11–T14, NEXT T15, `done_pulse` at T16.

## Test plan
- **Single block.** `funct3` = 1, count = 1, `src_base` = 0x100, `dst_base` = 0x200, ideal memory, L = 1.
  - Reads go to 0x100, 0x104, 0x108, 0x10C.
  - `ext_din` = {w3, w2, w1, w0}.
  - Writes go to 0x200–0x20C with `ext_dout` words in the same order.
  - `done_pulse` at T16; `stall` high for T0–T15.
- **Multi-block with wrap.** count = 3, `src_base` = 0xFFFFFFF0.
  - Block 0 reads 0xFFFFFFF0–0xFFFFFFFC.
  - Block 1 reads 0x0–0xC.
  - Block 2 reads 0x10–0x1C.
  - Exactly 3 `ext_start` pulses and 12 writes; `done_pulse` at T0 + 3·15 + 1.
- **Zero count and invalid select.**
  - count = 0, `funct3` = 2: `done_pulse` at T1, `err` = 0, no `mem_req`.
  - `funct3` = 3 with NUM_MODULES = 2: `done_pulse` = `err` = 1 at T1, no `mem_req`, no `ext_start`.
- **Backpressure.** `mem_gnt` held low for 5 cycles on the second read, and `mem_rvalid` delayed 3 cycles.
  - `mem_addr` stays 0x104 and `mem_req` stays high for all 5 cycles.
  - Data is still packed correctly.
  - `done_pulse` is delayed by exactly 5 + 2 cycles.
- **No re-accept.** `issue_valid` held high through DONE.
  - No second acceptance occurs in the DONE cycle.
  - A new acceptance occurs only in the IDLE cycle after it.
- **Reset mid-RUN.** `rst` asserted 2 cycles after `ext_start`.
  - All outputs return to 0 immediately and `issue_ready` returns to 1.
  - No `done_pulse`.
  - A later `ext_done` is ignored.
  - A new instruction runs to completion normally.
